// File: rtl/vend_pkg.sv
// Shared types, coin unit values and the price lookup helper for the vending controller.
package vend_pkg;

    typedef enum logic [1:0] {
        StCollect,
        StDispense,
        StChange
    } vend_state_e;

    // Coin values in nickel units
    localparam int unsigned NICKEL_U  = 1;
    localparam int unsigned DIME_U    = 2;
    localparam int unsigned QUARTER_U = 5;

    // Price vectors are zero-extended to this width before lookup
    localparam int unsigned PRICE_VEC_W = 256;

    // Returns the cw-bit price field of item idx from a packed price vector
    function automatic int unsigned price_of(input logic [PRICE_VEC_W-1:0] prices,
                                             input int unsigned idx,
                                             input int unsigned cw);
        logic [PRICE_VEC_W-1:0] shifted;
        shifted = prices >> (idx * cw);
        return shifted[31:0] & ((32'd1 << cw) - 32'd1);
    endfunction

endpackage

// File: rtl/vend_coin_sum.sv
// Combinational coin summation and over-credit reject decision.
// Optional VEND_QUARTER_EN adds a quarter (5 unit) coin input.
module vend_coin_sum
    import vend_pkg::*;
#(
    parameter int unsigned CW         = 4,
    parameter int unsigned MAX_CREDIT = 12
) (
    input  logic          nickel_i,
    input  logic          dime_i,
`ifdef VEND_QUARTER_EN
    input  logic          quarter_i,
`endif
    input  logic [CW-1:0] credit_i,
    output logic [CW+1:0] coin_val_o,
    output logic [CW+1:0] eff_o,
    output logic          reject_o
);

    localparam logic [CW+1:0] MaxEff = (CW+2)'(MAX_CREDIT);

    logic [CW+1:0] raw_sum;

    // Sum simultaneous coins; if the total would overflow the credit cap, keep old credit
    always_comb begin
        coin_val_o = '0;
        if (nickel_i) coin_val_o = coin_val_o + (CW+2)'(NICKEL_U);
        if (dime_i)   coin_val_o = coin_val_o + (CW+2)'(DIME_U);
`ifdef VEND_QUARTER_EN
        if (quarter_i) coin_val_o = coin_val_o + (CW+2)'(QUARTER_U);
`endif
        raw_sum  = (CW+2)'(credit_i) + coin_val_o;
        reject_o = (raw_sum > MaxEff);
        eff_o    = reject_o ? (CW+2)'(credit_i) : raw_sum;
    end

endmodule

// File: rtl/vend_fsm_multi.sv
// Multi-item vending controller: credit collection, purchase, dispense pulse,
// cancel/refund and serial nickel change return. All outputs are registered.
// Define VEND_QUARTER_EN to add the quarter_in coin input.
module vend_fsm_multi
    import vend_pkg::*;
#(
    parameter int unsigned             N_ITEMS    = 3,
    parameter int unsigned             CW         = 4,
    parameter logic [N_ITEMS*CW-1:0]   PRICES     = {4'd6, 4'd5, 4'd4},
    parameter int unsigned             MAX_CREDIT = 12,
    localparam int unsigned            SW         = (N_ITEMS > 1) ? $clog2(N_ITEMS) : 1
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          nickel_in,
    input  logic          dime_in,
`ifdef VEND_QUARTER_EN
    input  logic          quarter_in,
`endif
    input  logic [SW-1:0] item_sel,
    input  logic          select_valid,
    input  logic          cancel,
    output logic          dispense,
    output logic [SW-1:0] dispensed_item,
    output logic          nickel_out,
    output logic          coin_reject,
    output logic          insufficient,
    output logic          busy,
    output logic [CW-1:0] credit
);

    localparam logic [PRICE_VEC_W-1:0] PriceVec = PRICE_VEC_W'(PRICES);

    vend_state_e   state_q, state_d;
    logic [CW-1:0] credit_q, credit_d;
    logic [SW-1:0] item_q, item_d;
    logic          coin_reject_q, coin_reject_d;
    logic          insufficient_q, insufficient_d;

    logic [CW+1:0] coin_val;
    logic [CW+1:0] eff;
    logic          sum_reject;
    logic          coin_any;
    logic          item_ok;
    logic [CW+1:0] price;

    vend_coin_sum #(
        .CW         (CW),
        .MAX_CREDIT (MAX_CREDIT)
    ) u_coin_sum (
        .nickel_i   (nickel_in),
        .dime_i     (dime_in),
`ifdef VEND_QUARTER_EN
        .quarter_i  (quarter_in),
`endif
        .credit_i   (credit_q),
        .coin_val_o (coin_val),
        .eff_o      (eff),
        .reject_o   (sum_reject)
    );

    assign coin_any = (coin_val != '0);
    assign item_ok  = (32'(item_sel) < N_ITEMS);
    assign price    = (CW+2)'(price_of(PriceVec, 32'(item_sel), CW));

    // Next-state, next-credit and pulse decisions
    always_comb begin
        state_d        = state_q;
        credit_d       = credit_q;
        item_d         = item_q;
        coin_reject_d  = 1'b0;
        insufficient_d = 1'b0;
        unique case (state_q)
            StCollect: begin
                coin_reject_d = sum_reject;
                // eff never exceeds MAX_CREDIT, so it fits in CW bits
                credit_d      = eff[CW-1:0];
                if (cancel) begin
                    if (eff != '0) state_d = StChange;
                end else if (select_valid) begin
                    if (!item_ok || (eff < price)) begin
                        insufficient_d = 1'b1;
                    end else begin
                        state_d  = StDispense;
                        credit_d = CW'(eff - price);
                        item_d   = item_sel;
                    end
                end
            end
            StDispense: begin
                coin_reject_d = coin_any;
                state_d       = (credit_q != '0) ? StChange : StCollect;
            end
            StChange: begin
                coin_reject_d = coin_any;
                credit_d      = credit_q - CW'(1);
                if (credit_q <= CW'(1)) state_d = StCollect;
            end
            default: begin
                state_d  = StCollect;
                credit_d = '0;
            end
        endcase
    end

    // State and output registers with synchronous reset
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q        <= StCollect;
            credit_q       <= '0;
            item_q         <= '0;
            coin_reject_q  <= 1'b0;
            insufficient_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            credit_q       <= credit_d;
            item_q         <= item_d;
            coin_reject_q  <= coin_reject_d;
            insufficient_q <= insufficient_d;
        end
    end

    assign dispense       = (state_q == StDispense);
    assign dispensed_item = item_q;
    assign nickel_out     = (state_q == StChange);
    assign busy           = (state_q != StCollect);
    assign credit         = credit_q;
    assign coin_reject    = coin_reject_q;
    assign insufficient   = insufficient_q;

endmodule

// File: tb/tb_vend_fsm_multi.sv
// Scoreboard bench for vend_fsm_multi: the driver feeds a reference model that
// queues the expected output set per cycle; a monitor pops and compares them.
module tb_vend_fsm_multi;

    localparam int N_ITEMS    = 3;
    localparam int MAX_CREDIT = 12;
`ifdef VEND_QUARTER_EN
    localparam bit QEN = 1'b1;
`else
    localparam bit QEN = 1'b0;
`endif

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       nickel_in = 1'b0;
    logic       dime_in = 1'b0;
`ifdef VEND_QUARTER_EN
    logic       quarter_in = 1'b0;
`endif
    logic [1:0] item_sel = 2'd0;
    logic       select_valid = 1'b0;
    logic       cancel = 1'b0;
    logic       dispense;
    logic [1:0] dispensed_item;
    logic       nickel_out;
    logic       coin_reject;
    logic       insufficient;
    logic       busy;
    logic [3:0] credit;

    vend_fsm_multi dut (
        .clock          (clock),
        .reset          (reset),
        .nickel_in      (nickel_in),
        .dime_in        (dime_in),
`ifdef VEND_QUARTER_EN
        .quarter_in     (quarter_in),
`endif
        .item_sel       (item_sel),
        .select_valid   (select_valid),
        .cancel         (cancel),
        .dispense       (dispense),
        .dispensed_item (dispensed_item),
        .nickel_out     (nickel_out),
        .coin_reject    (coin_reject),
        .insufficient   (insufficient),
        .busy           (busy),
        .credit         (credit)
    );

    always #5 clock = ~clock;

    typedef struct {
        int due;
        bit disp;
        int item;
        bit chk_item;
        bit nk;
        bit rej;
        bit ins;
        bit busy;
        int cr;
    } exp_t;

    exp_t sb_q[$];     // expected outputs, stamped with the cycle they must appear
    exp_t sched[$];    // model: outputs of the remaining busy cycles
    int   m_credit = 0;
    int   prices[N_ITEMS] = '{4, 5, 6};
    int   cyc = 0;
    int   n_vec = 0;
    int   n_bad = 0;

    initial forever begin
        @(posedge clock);
        cyc++;
    end

    function automatic exp_t mk(bit disp, int item, bit nk, bit rej, bit ins, bit bsy, int cr);
        exp_t e;
        e.due = 0; e.disp = disp; e.item = item; e.chk_item = disp; e.nk = nk;
        e.rej = rej; e.ins = ins; e.busy = bsy; e.cr = cr;
        return e;
    endfunction

    // Queue k nickel cycles counting down from k, then the return to idle with no credit
    task automatic sched_refund(input int k);
        for (int j = k; j >= 1; j--) sched.push_back(mk(0, 0, 1, 0, 0, 1, j));
        sched.push_back(mk(0, 0, 0, 0, 0, 0, 0));
    endtask

    // Apply one cycle of inputs and record what the DUT must show after the next edge
    task automatic drive(input bit n, input bit d, input bit qq, input int sel,
                         input bit sv, input bit cn, input bit rst);
        exp_t e;
        int   coin;
        int   eff;
        bit   rej;
        @(negedge clock);
        reset = rst; nickel_in = n; dime_in = d;
`ifdef VEND_QUARTER_EN
        quarter_in = qq;
`endif
        item_sel = 2'(sel); select_valid = sv; cancel = cn;
        coin = (n ? 1 : 0) + (d ? 2 : 0) + ((QEN && qq) ? 5 : 0);
        if (rst) begin
            sched.delete();
            m_credit = 0;
            e = mk(0, 0, 0, 0, 0, 0, 0);
            e.chk_item = 1'b1;
        end else if (sched.size() > 0) begin
            e = sched.pop_front();
            e.rej = (coin != 0);
            m_credit = e.cr;
        end else begin
            eff = m_credit + coin;
            rej = (eff > MAX_CREDIT);
            if (rej) eff = m_credit;
            if (cn) begin
                if (eff > 0) begin
                    e = mk(0, 0, 1, rej, 0, 1, eff);
                    sched_refund(eff - 1);
                end else begin
                    e = mk(0, 0, 0, rej, 0, 0, 0);
                end
                m_credit = 0;
            end else if (sv && (sel >= N_ITEMS || eff < prices[sel % N_ITEMS])) begin
                e = mk(0, 0, 0, rej, 1, 0, eff);
                m_credit = eff;
            end else if (sv) begin
                e = mk(1, sel, 0, rej, 0, 1, eff - prices[sel]);
                sched_refund(eff - prices[sel]);
                m_credit = 0;
            end else begin
                e = mk(0, 0, 0, rej, 0, 0, eff);
                m_credit = eff;
            end
        end
        e.due = cyc + 1;
        sb_q.push_back(e);
    endtask

    task automatic idle(input int k);
        for (int i = 0; i < k; i++) drive(0, 0, 0, 0, 0, 0, 0);
    endtask

    // Monitor: compare every expectation that falls due after each clock edge
    initial forever begin
        @(posedge clock);
        #1;
        while (sb_q.size() > 0 && sb_q[0].due <= cyc) begin
            exp_t e;
            e = sb_q.pop_front();
            n_vec++;
            if (e.due < cyc) begin
                n_bad++;
                $display("FAIL stale_expectation cyc=%0d due=%0d", cyc, e.due);
            end else if (dispense !== e.disp || nickel_out !== e.nk || coin_reject !== e.rej ||
                         insufficient !== e.ins || busy !== e.busy || credit !== 4'(e.cr) ||
                         (e.chk_item && dispensed_item !== 2'(e.item))) begin
                n_bad++;
                $display("FAIL outputs cyc=%0d got disp=%b item=%0d nk=%b rej=%b ins=%b busy=%b cr=%0d exp disp=%b item=%0d nk=%b rej=%b ins=%b busy=%b cr=%0d",
                         cyc, dispense, dispensed_item, nickel_out, coin_reject, insufficient,
                         busy, credit, e.disp, e.item, e.nk, e.rej, e.ins, e.busy, e.cr);
            end
        end
    end

    initial begin
        drive(0, 0, 0, 0, 0, 0, 1);
        drive(0, 0, 0, 0, 0, 0, 1);
        idle(1);
        // dime, dime, buy item0 exactly
        drive(0, 1, 0, 0, 0, 0, 0); drive(0, 1, 0, 0, 0, 0, 0);
        drive(0, 0, 0, 0, 1, 0, 0); idle(2);
        // 3 dimes, buy item1, one nickel change
        for (int i = 0; i < 3; i++) drive(0, 1, 0, 0, 0, 0, 0);
        drive(0, 0, 0, 1, 1, 0, 0); idle(3);
        // 2 nickels, item2 refused, then cancel
        drive(1, 0, 0, 0, 0, 0, 0); drive(1, 0, 0, 0, 0, 0, 0);
        drive(0, 0, 0, 2, 1, 0, 0); idle(1);
        drive(0, 0, 0, 0, 0, 1, 0); idle(3);
        // credit 11, dime overflows, nickel reaches 12, refund with a coin mid-refund
        for (int i = 0; i < 5; i++) drive(0, 1, 0, 0, 0, 0, 0);
        drive(1, 0, 0, 0, 0, 0, 0);
        drive(0, 1, 0, 0, 0, 0, 0);
        drive(1, 0, 0, 0, 0, 0, 0);
        drive(0, 0, 0, 0, 0, 1, 0); idle(3);
        drive(0, 1, 0, 0, 0, 0, 0); idle(10);
        // select and cancel together with credit 4, coin during change
        drive(0, 1, 0, 0, 0, 0, 0); drive(0, 1, 0, 0, 0, 0, 0);
        drive(0, 0, 0, 0, 1, 1, 0); idle(1);
        drive(1, 1, 0, 0, 0, 0, 0); idle(4);
        // 5-unit refund interrupted by reset on the second nickel cycle
        drive(0, 1, 0, 0, 0, 0, 0); drive(0, 1, 0, 0, 0, 0, 0); drive(1, 0, 0, 0, 0, 0, 0);
        drive(0, 0, 0, 0, 0, 1, 0); idle(1);
        drive(0, 0, 0, 0, 0, 0, 1); idle(3);
        // out-of-range item index
        for (int i = 0; i < 4; i++) drive(1, 0, 0, 0, 0, 0, 0);
        drive(0, 0, 0, 3, 1, 0, 0); idle(1);
        // randomized traffic
        for (int i = 0; i < 3000; i++) begin
            bit n, d, qq, sv, cn, rst;
            int sel;
            n   = ($urandom_range(0, 2) == 0);
            d   = ($urandom_range(0, 2) == 0);
            qq  = ($urandom_range(0, 7) == 0);
            sv  = ($urandom_range(0, 5) == 0);
            cn  = ($urandom_range(0, 15) == 0);
            rst = ($urandom_range(0, 99) == 0);
            sel = int'($urandom_range(0, 3));
            drive(n, d, qq, sel, sv, cn, rst);
        end
        idle(2);
        repeat (2) @(posedge clock);
        #2;
        if (sb_q.size() != 0) begin
            n_bad++;
            $display("FAIL drain got %0d pending expectations, required 0", sb_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
